// File: rtl/param_step_controller.sv
// Multi-cycle step controller for the register/ALU datapath.
// Sequences IDLE/T0..T3 with run/hold/done handshaking.
module param_step_controller #(
    parameter int DATA_W     = 10,
    parameter int REG_W      = 2,
    parameter int AUTO_FETCH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              hold,
    input  logic [DATA_W-1:0] instr,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] imm,
    output logic              imm_en,
    output logic [REG_W-1:0]  rin,
    output logic [REG_W-1:0]  rout,
    output logic [3:0]        alu_op,
    output logic              enw,
    output logic              enr,
    output logic              ain,
    output logic              gin,
    output logic              gout,
    output logic              ext,
    output logic              irin
);

    localparam int IMM_W = DATA_W - 2 - REG_W;

    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3
    } state_t;

    state_t state;
    state_t nxt;
    state_t fin;

    logic             immf;
    logic             immsub;
    logic [REG_W-1:0] rx;
    logic [REG_W-1:0] ry;
    logic [3:0]       fn;
    logic [IMM_W-1:0] immv;

    logic c_imm;
    logic c_load;
    logic c_copy;
    logic c_un;
    logic c_bad;
    logic c_bin;

    assign immf   = instr[DATA_W-1];
    assign immsub = instr[DATA_W-2];
    assign rx     = instr[DATA_W-3 -: REG_W];
    assign ry     = instr[DATA_W-3-REG_W -: REG_W];
    assign fn     = instr[3:0];
    assign immv   = instr[IMM_W-1:0];

    // Mutually exclusive instruction classes; together they cover every word.
    assign c_imm  = immf;
    assign c_load = !immf && (fn == 4'h0);
    assign c_copy = !immf && (fn == 4'h1);
    assign c_un   = !immf && (fn == 4'h4 || fn == 4'h5);
    assign c_bad  = !immf && (fn >= 4'hC);
    assign c_bin  = !immf && !c_load && !c_copy
                    && !c_un && !c_bad;

    assign fin = (AUTO_FETCH != 0 && run) ? T0 : IDLE;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (!hold) begin
            case (state)
                IDLE:    if (run) nxt = T0;
                T0:      nxt = T1;
                T1:      nxt = (c_imm || c_bin || c_un) ? T2 : fin;
                T2:      nxt = c_un ? fin : T3;
                T3:      nxt = fin;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = !reset && (state != IDLE);
        done    = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        imm_en  = 1'b0;
        rin     = '0;
        rout    = '0;
        alu_op  = 4'h0;
        enw     = 1'b0;
        enr     = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        gout    = 1'b0;
        ext     = 1'b0;
        irin    = 1'b0;
        if (!reset && !hold) begin
            case (state)
                T0: begin
                    ext  = 1'b1;
                    irin = 1'b1;
                end
                T1: begin
                    unique case (1'b1)
                        c_imm, c_bin: begin
                            rout = rx;
                            enr  = 1'b1;
                            ain  = 1'b1;
                        end
                        c_load: begin
                            ext  = 1'b1;
                            rin  = rx;
                            enw  = 1'b1;
                            done = 1'b1;
                        end
                        c_copy: begin
                            rout = ry;
                            rin  = rx;
                            enr  = 1'b1;
                            enw  = 1'b1;
                            done = 1'b1;
                        end
                        c_un: begin
                            rout   = ry;
                            enr    = 1'b1;
                            gin    = 1'b1;
                            alu_op = fn;
                        end
                        c_bad: illegal = 1'b1;
                    endcase
                end
                T2: begin
                    unique case (1'b1)
                        c_imm: begin
                            gin    = 1'b1;
                            imm_en = 1'b1;
                            imm    = {{(DATA_W-IMM_W){1'b0}}, immv};
                            alu_op = immsub ? OP_SUB : OP_ADD;
                        end
                        c_un: begin
                            gout = 1'b1;
                            rin  = rx;
                            enw  = 1'b1;
                            done = 1'b1;
                        end
                        default: begin
                            rout   = ry;
                            enr    = 1'b1;
                            gin    = 1'b1;
                            alu_op = fn;
                        end
                    endcase
                end
                T3: begin
                    gout = 1'b1;
                    rin  = rx;
                    enw  = 1'b1;
                    done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_step_controller.sv
// Directed bench for param_step_controller.
// Strobe vector: ext irin enr enw ain gin gout done illegal imm_en.
module tb_param_step_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       hold;
    logic [9:0] instr;

    logic       busy, done, illegal, imm_en;
    logic [9:0] imm;
    logic [1:0] rin, rout;
    logic [3:0] alu_op;
    logic       enw, enr, ain, gin, gout, ext, irin;

    logic       busy_b, done_b, illegal_b, imm_en_b;
    logic [9:0] imm_b;
    logic [1:0] rin_b, rout_b;
    logic [3:0] alu_op_b;
    logic       enw_b, enr_b, ain_b, gin_b, gout_b, ext_b, irin_b;

    logic [9:0] strb;
    logic [9:0] strb_b;

    int errors = 0;
    int checks = 0;

    assign strb = {ext, irin, enr, enw, ain,
                   gin, gout, done, illegal, imm_en};
    assign strb_b = {ext_b, irin_b, enr_b, enw_b, ain_b,
                     gin_b, gout_b, done_b, illegal_b, imm_en_b};

    always #5 clk = ~clk;

    param_step_controller #(
        .DATA_W(10), .REG_W(2), .AUTO_FETCH(1)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .hold(hold),
        .instr(instr), .busy(busy), .done(done),
        .illegal(illegal), .imm(imm), .imm_en(imm_en),
        .rin(rin), .rout(rout), .alu_op(alu_op),
        .enw(enw), .enr(enr), .ain(ain), .gin(gin),
        .gout(gout), .ext(ext), .irin(irin)
    );

    param_step_controller #(
        .DATA_W(10), .REG_W(2), .AUTO_FETCH(0)
    ) dut_b (
        .clk(clk), .reset(reset), .run(run), .hold(hold),
        .instr(instr), .busy(busy_b), .done(done_b),
        .illegal(illegal_b), .imm(imm_b), .imm_en(imm_en_b),
        .rin(rin_b), .rout(rout_b), .alu_op(alu_op_b),
        .enw(enw_b), .enr(enr_b), .ain(ain_b), .gin(gin_b),
        .gout(gout_b), .ext(ext_b), .irin(irin_b)
    );

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        hold  = 1'b0;
        instr = 10'h000;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, strb} !== 11'h0) begin
            errors++;
            $display("FAIL rst_strb got %h want 000", {busy, strb});
        end
        checks++;
        if ({rin, rout, alu_op, imm} !== 18'h0) begin
            errors++;
            $display("FAIL rst_sel got %h want 0",
                     {rin, rout, alu_op, imm});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, strb} !== 11'h0) begin
            errors++;
            $display("FAIL rst_idle got %h want 000", {busy, strb});
        end
        @(negedge clk);
        checks++;
        if ({busy, strb} !== {1'b1, 10'b11_0000_0000}) begin
            errors++;
            $display("FAIL rst_t0 got %h want 700", {busy, strb});
        end
    endtask

    task automatic test_add();
        do_reset();
        instr = 10'h062;
        run   = 1'b1;
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (strb !== 10'b11_0000_0000) begin
            errors++;
            $display("FAIL add_t0 got %b want 1100000000", strb);
        end
        @(negedge clk);
        checks++;
        if ({strb, rout, rin} !== {10'b00_1010_0000, 2'd1, 2'd0}) begin
            errors++;
            $display("FAIL add_t1 got %b/%0d/%0d", strb, rout, rin);
        end
        @(negedge clk);
        checks++;
        if ({strb, rout, alu_op} !== {10'b00_1001_0000, 2'd2, 4'h2}) begin
            errors++;
            $display("FAIL add_t2 got %b/%0d/%h", strb, rout, alu_op);
        end
        @(negedge clk);
        checks++;
        if ({strb, rin, busy} !== {10'b00_0100_1100, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL add_t3 got %b/%0d/%b", strb, rin, busy);
        end
        @(negedge clk);
        checks++;
        if ({busy, strb} !== 11'h0) begin
            errors++;
            $display("FAIL add_idle got %h want 000", {busy, strb});
        end
    endtask

    task automatic test_subi();
        do_reset();
        instr = 10'h3C5;
        run   = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if ({strb, rout} !== {10'b00_1010_0000, 2'd3}) begin
            errors++;
            $display("FAIL subi_t1 got %b/%0d", strb, rout);
        end
        @(negedge clk);
        checks++;
        if ({strb, imm, alu_op} !== {10'b00_0001_0001, 10'h005, 4'h3}) begin
            errors++;
            $display("FAIL subi_t2 got %b/%h/%h", strb, imm, alu_op);
        end
        @(negedge clk);
        checks++;
        if ({strb, rin, imm} !== {10'b00_0100_1100, 2'd3, 10'h0}) begin
            errors++;
            $display("FAIL subi_t3 got %b/%0d/%h", strb, rin, imm);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        instr = 10'h04C;
        run   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, strb} !== {1'b1, 10'b00_0000_0010}) begin
            errors++;
            $display("FAIL ill_t1 got %b want 10000000010", {busy, strb});
        end
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (strb !== 10'b11_0000_0000) begin
            errors++;
            $display("FAIL ill_refetch got %b want 1100000000", strb);
        end
    endtask

    task automatic test_hold();
        do_reset();
        instr = 10'h062;
        run   = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, strb, rout, alu_op} !== {1'b1, 16'h0}) begin
                errors++;
                $display("FAIL hold_%0d got %b/%0d/%h",
                         i, strb, rout, alu_op);
            end
        end
        hold = 1'b0;
        #1;
        checks++;
        if ({strb, rout, alu_op} !== {10'b00_1001_0000, 2'd2, 4'h2}) begin
            errors++;
            $display("FAIL hold_resume got %b/%0d/%h", strb, rout, alu_op);
        end
        @(negedge clk);
        checks++;
        if ({strb, rin} !== {10'b00_0100_1100, 2'd1}) begin
            errors++;
            $display("FAIL hold_t3 got %b/%0d", strb, rin);
        end
    endtask

    task automatic test_unary();
        do_reset();
        instr = 10'h0A4;
        run   = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if ({strb, rout, alu_op} !== {10'b00_1001_0000, 2'd2, 4'h4}) begin
            errors++;
            $display("FAIL inv_t1 got %b/%0d/%h", strb, rout, alu_op);
        end
        @(negedge clk);
        checks++;
        if ({strb, rin} !== {10'b00_0100_1100, 2'd2}) begin
            errors++;
            $display("FAIL inv_t2 got %b/%0d", strb, rin);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL inv_idle got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        instr = 10'h0C0;
        run   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({strb, rin} !== {10'b10_0100_0100, 2'd3}) begin
            errors++;
            $display("FAIL b2b_load got %b/%0d", strb, rin);
        end
        checks++;
        if ({busy_b, done_b} !== 2'b11) begin
            errors++;
            $display("FAIL af0_load got %b want 11", {busy_b, done_b});
        end
        instr = 10'h061;
        @(negedge clk);
        checks++;
        if ({busy, strb} !== {1'b1, 10'b11_0000_0000}) begin
            errors++;
            $display("FAIL b2b_t0 got %b", {busy, strb});
        end
        checks++;
        if ({busy_b, strb_b} !== 11'h0) begin
            errors++;
            $display("FAIL af0_idle got %b", {busy_b, strb_b});
        end
        @(negedge clk);
        run = 1'b0;
        checks++;
        if ({strb, rout, rin} !== {10'b00_1100_0100, 2'd2, 2'd1}) begin
            errors++;
            $display("FAIL b2b_copy got %b/%0d/%0d", strb, rout, rin);
        end
        checks++;
        if (strb_b !== 10'b11_0000_0000) begin
            errors++;
            $display("FAIL af0_t0 got %b", strb_b);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr = 10'h062;
        run   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, strb, rout} !== 13'h0) begin
            errors++;
            $display("FAIL rmid_gate got %b", {busy, strb, rout});
        end
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        #1;
        checks++;
        if ({busy, strb} !== 11'h0) begin
            errors++;
            $display("FAIL rmid_idle got %b", {busy, strb});
        end
        @(negedge clk);
        checks++;
        if ({busy, enw, done} !== 3'b0) begin
            errors++;
            $display("FAIL rmid_nowrite got %b", {busy, enw, done});
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        hold  = 1'b0;
        instr = '0;
        test_reset();
        test_add();
        test_subi();
        test_illegal();
        test_hold();
        test_unary();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
